g_func_pipe: RTL and testbench

G_FUNC_PIPE -- requirements
Module: g_func_pipe

---
 rtl/twofish_pkg.sv | 75 +++++++
 rtl/twofish_qbox.sv | 25 ++
 rtl/g_func_pipe.sv | 108 ++++++++++
 tb/tb_g_func_pipe.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/twofish_pkg.sv
// Shared Twofish constants and helpers for the g-function pipeline: q-box nibble tables,
// per-lane q0/q1 ordering, MDS matrix, GF(2^8) arithmetic and parameter legality.
package twofish_pkg;

  localparam logic [8:0] GfPoly = 9'h169;

  // QT[q][t][n]: nibble table t (t0..t3) of permutation q (0 = q0, 1 = q1).
  localparam logic [3:0] QT [2][4][16] = '{
    '{
      '{4'h8, 4'h1, 4'h7, 4'hD, 4'h6, 4'hF, 4'h3, 4'h2,
        4'h0, 4'hB, 4'h5, 4'h9, 4'hE, 4'hC, 4'hA, 4'h4},
      '{4'hE, 4'hC, 4'hB, 4'h8, 4'h1, 4'h2, 4'h3, 4'h5,
        4'hF, 4'h4, 4'hA, 4'h6, 4'h7, 4'h0, 4'h9, 4'hD},
      '{4'hB, 4'hA, 4'h5, 4'hE, 4'h6, 4'hD, 4'h9, 4'h0,
        4'hC, 4'h8, 4'hF, 4'h3, 4'h2, 4'h4, 4'h7, 4'h1},
      '{4'hD, 4'h7, 4'hF, 4'h4, 4'h1, 4'h2, 4'h6, 4'hE,
        4'h9, 4'hB, 4'h3, 4'h0, 4'h8, 4'h5, 4'hC, 4'hA}
    },
    '{
      '{4'h2, 4'h8, 4'hB, 4'hD, 4'hF, 4'h7, 4'h6, 4'hE,
        4'h3, 4'h1, 4'h9, 4'h4, 4'h0, 4'hA, 4'hC, 4'h5},
      '{4'h1, 4'hE, 4'h2, 4'hB, 4'h4, 4'hC, 4'h3, 4'h7,
        4'h6, 4'hD, 4'hA, 4'h5, 4'hF, 4'h9, 4'h0, 4'h8},
      '{4'h4, 4'hC, 4'h7, 4'h5, 4'h1, 4'h6, 4'h9, 4'hA,
        4'h0, 4'hE, 4'hD, 4'h8, 4'h2, 4'hB, 4'h3, 4'hF},
      '{4'hB, 4'h9, 4'h5, 4'h1, 4'hC, 4'h3, 4'hD, 4'hE,
        4'h6, 4'h4, 4'h7, 4'hF, 4'h2, 4'h0, 4'h8, 4'hA}
    }
  };

  // Bit n of QSel[lane] picks q1 for chain step n of a 256-bit key; shorter keys skip the
  // leading 4-K steps.
  localparam logic [4:0] QSel [4] = '{5'b10011, 5'b00110, 5'b11000, 5'b01101};

  localparam logic [7:0] Mds [4][4] = '{
    '{8'h01, 8'hEF, 8'h5B, 8'h5B},
    '{8'h5B, 8'hEF, 8'hEF, 8'h01},
    '{8'hEF, 8'h5B, 8'h01, 8'hEF},
    '{8'hEF, 8'h01, 8'hEF, 8'h5B}
  };

  function automatic bit k_legal(input int k);
    return (k == 2) || (k == 3) || (k == 4);
  endfunction

  function automatic bit pipe_legal(input int p);
    return (p == 1) || (p == 2);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc ^= sh;
      sh = sh[7] ? ((sh << 1) ^ GfPoly[7:0]) : (sh << 1);
    end
    return acc;
  endfunction

  // Operand and result are packed MSB-first: byte 0 in bits [31:24].
  function automatic logic [31:0] mds_mul(input logic [31:0] y);
    logic [31:0] z;
    logic [7:0]  acc;
    z = '0;
    for (int i = 0; i < 4; i++) begin
      acc = '0;
      for (int j = 0; j < 4; j++) acc ^= gf_mul(Mds[i][j], y[31-8*j -: 8]);
      z[31-8*i -: 8] = acc;
    end
    return z;
  endfunction

endpackage

// File: rtl/twofish_qbox.sv
// Twofish q0/q1 byte permutation built from the four 4-bit substitution tables.
module twofish_qbox
  import twofish_pkg::*;
#(
  parameter bit Q1 = 1'b0
) (
  input  logic [7:0] x,
  output logic [7:0] y
);

  localparam int Sel = Q1 ? 1 : 0;

  logic [3:0] a0, b0, a1, b1, a2, b2, a3, b3;

  assign a0 = x[7:4];
  assign b0 = x[3:0];
  assign a1 = a0 ^ b0;
  assign b1 = a0 ^ {b0[0], b0[3:1]} ^ {a0[0], 3'b000};
  assign a2 = QT[Sel][0][a1];
  assign b2 = QT[Sel][1][b1];
  assign a3 = a2 ^ b2;
  assign b3 = a2 ^ {b2[0], b2[3:1]} ^ {a2[0], 3'b000};
  assign y  = {QT[Sel][3][b3], QT[Sel][2][a3]};

endmodule

// File: rtl/g_func_pipe.sv
// Pipelined Twofish g function: per-lane h-chain keyed by captured S-words, then MDS,
// with a valid/ready handshake and a single global stall enable.
module g_func_pipe
  import twofish_pkg::*;
#(
  parameter int K    = 2,
  parameter int PIPE = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load,
  input  logic [127:0] s_in,
  output logic         key_valid,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  x_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  z_out
);

  if (!k_legal(K) || !pipe_legal(PIPE)) begin : g_bad_param
    $error("g_func_pipe: K must be 2..4 and PIPE must be 1 or 2");
  end

  logic [31:0] s_q [K];
  logic        key_valid_q;
  logic        unused_s_in;

  assign unused_s_in = ^s_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < K; i++) s_q[i] <= '0;
      key_valid_q <= 1'b0;
    end else if (key_load) begin
      for (int i = 0; i < K; i++) s_q[i] <= s_in[32*i +: 32];
      key_valid_q <= 1'b1;
    end
  end

  logic [7:0]  h_byte [4];
  logic [31:0] h_word;

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] lvl_in  [K+1];
    logic [7:0] lvl_out [K+1];
    for (genvar n = 0; n <= K; n++) begin : g_lvl
      if (n == 0) begin : g_first
        assign lvl_in[n] = x_in[31-8*l -: 8];
      end else begin : g_mix
        assign lvl_in[n] = lvl_out[n-1] ^ s_q[K-n][8*l +: 8];
      end
      twofish_qbox #(
        .Q1(QSel[l][4-K+n])
      ) u_qbox (
        .x(lvl_in[n]),
        .y(lvl_out[n])
      );
    end
    assign h_byte[l] = lvl_out[K];
  end

  assign h_word = {h_byte[0], h_byte[1], h_byte[2], h_byte[3]};

  logic        en;
  logic        in_fire;
  logic        vo_q;
  logic [31:0] z_q;

  assign en       = !vo_q || out_ready;
  assign in_ready = en && key_valid_q && !rst;
  assign in_fire  = in_valid && in_ready;

  // Words are keyed in the transfer cycle; later stages never see the key registers.
  if (PIPE == 2) begin : g_pipe2
    logic [31:0] y_q;
    logic        v1_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        y_q  <= '0;
        v1_q <= 1'b0;
        z_q  <= '0;
        vo_q <= 1'b0;
      end else if (en) begin
        y_q  <= h_word;
        v1_q <= in_fire;
        z_q  <= mds_mul(y_q);
        vo_q <= v1_q;
      end
    end
  end else begin : g_pipe1
    always_ff @(posedge clk) begin
      if (rst) begin
        z_q  <= '0;
        vo_q <= 1'b0;
      end else if (en) begin
        z_q  <= mds_mul(h_word);
        vo_q <= in_fire;
      end
    end
  end

  assign key_valid = key_valid_q;
  assign out_valid = vo_q;
  assign z_out     = z_q;

endmodule

// File: tb/tb_g_func_pipe.sv
// Self-checking bench for g_func_pipe: three configurations driven one at a time against a
// behavioural Twofish h/MDS reference and an in-order scoreboard.
module tb_g_func_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         key_load  [3];
  logic [127:0] s_in      [3];
  logic         in_valid  [3];
  logic [31:0]  x_in      [3];
  logic         out_ready [3];
  logic         key_valid [3];
  logic         in_ready  [3];
  logic         out_valid [3];
  logic [31:0]  z_out     [3];

  localparam int KD [3] = '{2, 4, 3};

  g_func_pipe #(.K(2), .PIPE(2)) u_a (
    .clk(clk), .rst(rst), .key_load(key_load[0]), .s_in(s_in[0]), .key_valid(key_valid[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .x_in(x_in[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .z_out(z_out[0])
  );
  g_func_pipe #(.K(4), .PIPE(1)) u_b (
    .clk(clk), .rst(rst), .key_load(key_load[1]), .s_in(s_in[1]), .key_valid(key_valid[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .x_in(x_in[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .z_out(z_out[1])
  );
  g_func_pipe #(.K(3), .PIPE(2)) u_c (
    .clk(clk), .rst(rst), .key_load(key_load[2]), .s_in(s_in[2]), .key_valid(key_valid[2]),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .x_in(x_in[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .z_out(z_out[2])
  );

  // Reference model: h written as the nested q/XOR formula, MDS as a carry-less product
  // followed by polynomial reduction.
  localparam int QTAB [2][4][16] = '{
    '{'{'h8,'h1,'h7,'hD,'h6,'hF,'h3,'h2,'h0,'hB,'h5,'h9,'hE,'hC,'hA,'h4},
      '{'hE,'hC,'hB,'h8,'h1,'h2,'h3,'h5,'hF,'h4,'hA,'h6,'h7,'h0,'h9,'hD},
      '{'hB,'hA,'h5,'hE,'h6,'hD,'h9,'h0,'hC,'h8,'hF,'h3,'h2,'h4,'h7,'h1},
      '{'hD,'h7,'hF,'h4,'h1,'h2,'h6,'hE,'h9,'hB,'h3,'h0,'h8,'h5,'hC,'hA}},
    '{'{'h2,'h8,'hB,'hD,'hF,'h7,'h6,'hE,'h3,'h1,'h9,'h4,'h0,'hA,'hC,'h5},
      '{'h1,'hE,'h2,'hB,'h4,'hC,'h3,'h7,'h6,'hD,'hA,'h5,'hF,'h9,'h0,'h8},
      '{'h4,'hC,'h7,'h5,'h1,'h6,'h9,'hA,'h0,'hE,'hD,'h8,'h2,'hB,'h3,'hF},
      '{'hB,'h9,'h5,'h1,'hC,'h3,'hD,'hE,'h6,'h4,'h7,'hF,'h2,'h0,'h8,'hA}}
  };
  localparam int Q4S [4] = '{1, 0, 0, 1};
  localparam int Q3S [4] = '{1, 1, 0, 0};
  localparam int QC  [4] = '{0, 1, 0, 1};
  localparam int QB  [4] = '{0, 0, 1, 1};
  localparam int QA  [4] = '{1, 0, 1, 0};
  localparam int MDSM [4][4] = '{'{'h01, 'hEF, 'h5B, 'h5B}, '{'h5B, 'hEF, 'hEF, 'h01},
                                 '{'hEF, 'h5B, 'h01, 'hEF}, '{'hEF, 'h01, 'hEF, 'h5B}};

  function automatic int qperm(input int s, input int x);
    int a, b, ta, tb;
    a  = x / 16;
    b  = x % 16;
    ta = a ^ b;
    tb = a ^ ((b >> 1) | ((b & 1) << 3)) ^ ((8 * a) % 16);
    a  = QTAB[s][0][ta];
    b  = QTAB[s][1][tb];
    ta = a ^ b;
    tb = a ^ ((b >> 1) | ((b & 1) << 3)) ^ ((8 * a) % 16);
    return QTAB[s][3][tb] * 16 + QTAB[s][2][ta];
  endfunction

  function automatic int gmul(input int a, input int b);
    int p;
    p = 0;
    for (int i = 0; i < 8; i++) if (((b >> i) & 1) != 0) p ^= a << i;
    for (int i = 14; i >= 8; i--) if (((p >> i) & 1) != 0) p ^= 'h169 << (i - 8);
    return p;
  endfunction

  function automatic int kb(input logic [127:0] s, input int w, input int j);
    return int'(s[32*w + 8*j +: 8]);
  endfunction

  function automatic logic [31:0] g_model(input int k, input logic [127:0] s,
                                          input logic [31:0] x);
    int y [4];
    int z;
    logic [31:0] r;
    for (int j = 0; j < 4; j++) begin
      y[j] = int'(x[24 - 8*j +: 8]);
      if (k == 4) y[j] = qperm(Q4S[j], y[j]) ^ kb(s, 3, j);
      if (k >= 3) y[j] = qperm(Q3S[j], y[j]) ^ kb(s, 2, j);
      y[j] = qperm(QA[j], qperm(QB[j], qperm(QC[j], y[j]) ^ kb(s, 1, j)) ^ kb(s, 0, j));
    end
    r = '0;
    for (int i = 0; i < 4; i++) begin
      z = 0;
      for (int j = 0; j < 4; j++) z ^= gmul(MDSM[i][j], y[j]);
      r = {r[23:0], z[7:0]};
    end
    return r;
  endfunction

  int n_checks = 0;
  int n_err    = 0;
  int n_pop    = 0;
  logic [31:0]  exp_q [$];
  logic [127:0] key_m [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus on DUT d, entered and left at a falling edge.
  task automatic cycle(input int d, input bit kl, input logic [127:0] s, input bit iv,
                       input logic [31:0] x, input bit ordy, output bit acc);
    key_load[d]  = kl;
    s_in[d]      = s;
    in_valid[d]  = iv;
    x_in[d]      = x;
    out_ready[d] = ordy;
    #1;
    acc = in_valid[d] && in_ready[d];
    if (out_valid[d] && out_ready[d]) begin
      chk("unexpected_out", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        chk("z_out", z_out[d], exp_q.pop_front());
        n_pop++;
      end
    end
    if (acc) exp_q.push_back(g_model(KD[d], key_m[d], x));
    if (kl) key_m[d] = s;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int d, input int budget);
    bit a;
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cycle(d, 1'b0, '0, 1'b0, '0, 1'b1, a);
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit           a;
    int           idx, n, p0;
    logic [31:0]  w [3];
    logic [31:0]  zhold;
    logic [127:0] rk, rk2;

    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      key_load[d] = 1'b0; s_in[d] = '0; in_valid[d] = 1'b0;
      x_in[d] = '0; out_ready[d] = 1'b0; key_m[d] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_key_valid%0d", d), key_valid[d], 0);
      chk($sformatf("rst_out_valid%0d", d), out_valid[d], 0);
      chk($sformatf("rst_in_ready%0d", d), in_ready[d], 0);
      chk($sformatf("rst_z_out%0d", d), z_out[d], 0);
    end
    rst = 1'b0;

    // No key yet: nothing may be accepted.
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1'b0, '0, 1'b1, $urandom, 1'b1, a);
      chk("nokey_accept", a, 0);
      chk("nokey_in_ready", in_ready[0], 0);
    end
    chk("nokey_out_valid", out_valid[0], 0);
    in_valid[0] = 1'b0;

    // Zero key, x=0: exactly two cycles of latency.
    key_load[0] = 1'b1;
    s_in[0]     = '0;
    @(posedge clk); @(negedge clk);
    key_load[0] = 1'b0;
    key_m[0]    = '0;
    chk("key_valid_set", key_valid[0], 1);
    chk("in_ready_set", in_ready[0], 1);
    in_valid[0]  = 1'b1;
    x_in[0]      = '0;
    out_ready[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid[0] = 1'b0;
    chk("lat_cycle1", out_valid[0], 0);
    @(posedge clk); @(negedge clk);
    chk("lat_cycle2", out_valid[0], 1);
    chk("g0_zero_key", z_out[0], g_model(2, '0, '0));
    @(posedge clk); @(negedge clk);
    chk("lat_after", out_valid[0], 0);

    // Back-pressure with three words offered.
    rk = {$urandom, $urandom, $urandom, $urandom};
    cycle(0, 1'b1, rk, 1'b0, '0, 1'b1, a);
    for (int i = 0; i < 3; i++) w[i] = $urandom;
    idx = 0;
    p0  = n_pop;
    zhold = '0;
    for (int c = 0; c < 5; c++) begin
      cycle(0, 1'b0, '0, idx < 3, (idx < 3) ? w[idx] : 32'h0, 1'b0, a);
      if (a) idx++;
      if (c == 1) zhold = z_out[0];
      if (c >= 1) begin
        chk("stall_in_ready", in_ready[0], 0);
        chk("stall_out_valid", out_valid[0], 1);
      end
      if (c >= 2) chk("stall_z_hold", z_out[0], zhold);
    end
    chk("stall_accepted", idx, 2);
    n = 0;
    while ((idx < 3 || exp_q.size() != 0) && n < 20) begin
      cycle(0, 1'b0, '0, idx < 3, (idx < 3) ? w[idx] : 32'h0, 1'b1, a);
      if (a) idx++;
      n++;
    end
    chk("stall_results", n_pop - p0, 3);

    // Reset with two words in flight; a simultaneous key_load and offer must lose.
    cycle(0, 1'b0, '0, 1'b1, $urandom, 1'b1, a);
    cycle(0, 1'b0, '0, 1'b1, $urandom, 1'b1, a);
    rst         = 1'b1;
    key_load[0] = 1'b1;
    s_in[0]     = {$urandom, $urandom, $urandom, $urandom};
    in_valid[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst_flush_out_valid", out_valid[0], 0);
    chk("rst_flush_key_valid", key_valid[0], 0);
    chk("rst_flush_in_ready", in_ready[0], 0);
    rst         = 1'b0;
    key_load[0] = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1'b0, '0, 1'b1, $urandom, 1'b1, a);
      chk("post_rst_accept", a, 0);
      chk("post_rst_out_valid", out_valid[0], 0);
      chk("post_rst_key_valid", key_valid[0], 0);
    end
    in_valid[0] = 1'b0;

    // K=4, PIPE=1 streaming: one result per cycle, in order.
    rk = {$urandom, $urandom, $urandom, $urandom};
    cycle(1, 1'b1, rk, 1'b0, '0, 1'b1, a);
    p0 = n_pop;
    for (int i = 0; i < 1000; i++) begin
      cycle(1, 1'b0, '0, 1'b1, $urandom, 1'b1, a);
      chk("tp_accept", a, 1);
      chk("tp_out_valid", out_valid[1], 1);
    end
    drain(1, 5);
    chk("tp_count", n_pop - p0, 1000);

    // K=3: key swap in the same cycle as an accepted word.
    rk  = {$urandom, $urandom, $urandom, $urandom};
    rk2 = {$urandom, $urandom, $urandom, $urandom};
    cycle(2, 1'b1, rk, 1'b0, '0, 1'b1, a);
    p0 = n_pop;
    cycle(2, 1'b1, rk2, 1'b1, $urandom, 1'b1, a);
    chk("swap_accept_old", a, 1);
    cycle(2, 1'b0, '0, 1'b1, $urandom, 1'b1, a);
    chk("swap_accept_new", a, 1);
    for (int i = 0; i < 6; i++) cycle(2, 1'b0, '0, 1'b1, $urandom, 1'b1, a);
    drain(2, 10);
    chk("swap_count", n_pop - p0, 8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
